// File: rtl/mfp_uart_transmitter.sv
// Byte-serial 8N1 UART transmitter with an internal circular FIFO.
// Bytes enter over a valid/ready handshake and are shifted out LSB first on tx.
module mfp_uart_transmitter #(
    parameter int clock_frequency = 50000000,
    parameter int baud_rate       = 115200,
    parameter int fifo_depth_log2 = 3
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [7:0]               byte_data,
    input  logic                     byte_valid,
    output logic                     byte_ready,
    output logic                     tx,
    output logic                     busy,
    output logic [fifo_depth_log2:0] fifo_level
);

    localparam int cycles_per_bit = clock_frequency / baud_rate;
    localparam int baud_width     = $clog2(cycles_per_bit);
    localparam int level_width    = fifo_depth_log2 + 1;
    localparam int depth          = 1 << fifo_depth_log2;

    localparam logic [baud_width-1:0]      baud_last  = baud_width'(cycles_per_bit - 1);
    localparam logic [baud_width-1:0]      baud_one   = baud_width'(1);
    localparam logic [level_width-1:0]     level_full = level_width'(depth);
    localparam logic [level_width-1:0]     level_one  = level_width'(1);
    localparam logic [fifo_depth_log2-1:0] ptr_one    = fifo_depth_log2'(1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                     state, state_next;
    logic [baud_width-1:0]      baud_count, baud_count_next;
    logic [2:0]                 bit_index, bit_index_next;
    logic [7:0]                 shift, shift_next;
    logic [7:0]                 mem [depth];
    logic [fifo_depth_log2-1:0] wr_ptr, rd_ptr;
    logic [level_width-1:0]     level_next;
    logic                       push, pop, bit_done, tx_next, busy_next;

    // No pass-through: a full FIFO refuses even when a pop happens this cycle.
    assign byte_ready = (fifo_level != level_full);
    assign push       = byte_valid & byte_ready;
    assign bit_done   = (baud_count == baud_last);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_next      = state;
        baud_count_next = baud_count + baud_one;
        bit_index_next  = bit_index;
        pop             = 1'b0;

        case (state)
            IDLE: begin
                baud_count_next = '0;
                if (fifo_level != '0) begin
                    pop        = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                if (bit_done) begin
                    baud_count_next = '0;
                    bit_index_next  = '0;
                    state_next      = DATA;
                end
            end
            DATA: begin
                if (bit_done) begin
                    baud_count_next = '0;
                    bit_index_next  = bit_index + 3'd1;
                    if (bit_index == 3'd7) state_next = STOP;
                end
            end
            STOP: begin
                // Back-to-back frames: the next start bit follows the stop bit directly.
                if (bit_done) begin
                    baud_count_next = '0;
                    if (fifo_level != '0) begin
                        pop        = 1'b1;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        shift_next = pop ? mem[rd_ptr] : shift;

        case ({push, pop})
            2'b10:   level_next = fifo_level + level_one;
            2'b01:   level_next = fifo_level - level_one;
            default: level_next = fifo_level;
        endcase

        // Outputs are computed from next state so they can be registered without lag.
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[bit_index_next];
            default: tx_next = 1'b1;
        endcase

        busy_next = (state_next != IDLE) || (level_next != '0);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= IDLE;
            baud_count <= '0;
            bit_index  <= '0;
            shift      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            tx         <= 1'b1;
            busy       <= 1'b0;
        end else begin
            state      <= state_next;
            baud_count <= baud_count_next;
            bit_index  <= bit_index_next;
            shift      <= shift_next;
            fifo_level <= level_next;
            tx         <= tx_next;
            busy       <= busy_next;
            if (push) wr_ptr <= wr_ptr + ptr_one;
            if (pop)  rd_ptr <= rd_ptr + ptr_one;
        end
    end

    // NOTE: storage is deliberately not reset; the cleared pointers and level make stale entries unreachable.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= byte_data;
    end

endmodule

// File: tb/tb_mfp_uart_transmitter.sv
// Self-checking bench for mfp_uart_transmitter at 16 clocks per bit, FIFO depth 8.
// A timeline model predicts tx, busy, fifo_level and byte_ready for every cycle.
module tb_mfp_uart_transmitter;

    localparam int cpb   = 16;
    localparam int frame = 10 * cpb;
    localparam int depth = 8;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] byte_data = 8'h00;
    logic       byte_valid = 1'b0;
    logic       byte_ready;
    logic       tx;
    logic       busy;
    logic [3:0] fifo_level;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: queued bytes, the byte on the line, and the edge its start bit began.
    logic [7:0] model_q[$];
    logic [7:0] cur_byte = 8'h00;
    longint     cycle = 0;
    longint     frame_start = -1000;

    typedef struct {
        int   offset;
        logic tx;
        logic busy;
        int   level;
    } vec_t;

    vec_t a5_table[16];

    always #5 clock = ~clock;

    mfp_uart_transmitter #(
        .clock_frequency(16),
        .baud_rate      (1),
        .fifo_depth_log2(3)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .byte_data (byte_data),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .tx        (tx),
        .busy      (busy),
        .fifo_level(fifo_level)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cycle, act, exp);
        end
    endtask

    function automatic logic model_tx();
        int pos;
        if (cycle - frame_start < frame) begin
            pos = int'((cycle - frame_start) / cpb);
            if (pos == 0) return 1'b0;
            if (pos <= 8) return cur_byte[pos-1];
        end
        return 1'b1;
    endfunction

    function automatic logic model_busy();
        return (cycle - frame_start < frame) || (model_q.size() != 0);
    endfunction

    // One clock: drive inputs, advance the model across the edge, compare outputs after it.
    task automatic tick(input logic rst_v, input logic valid_v, input logic [7:0] data_v);
        logic ready_exp;
        ready_exp = (model_q.size() != depth);
        if (rst_v) check("byte_ready", byte_ready, ready_exp);
        reset_n    = rst_v;
        byte_valid = valid_v;
        byte_data  = data_v;
        @(posedge clock);
        cycle++;
        if (!rst_v) begin
            model_q.delete();
            frame_start = -1000;
        end else begin
            if (model_q.size() != 0 && cycle >= frame_start + frame) begin
                cur_byte    = model_q.pop_front();
                frame_start = cycle;
            end
            if (valid_v && ready_exp) model_q.push_back(data_v);
        end
        #1;
        check("tx", tx, model_tx());
        check("busy", busy, model_busy());
        check("fifo_level", fifo_level, model_q.size());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 8'h00);
    endtask

    initial begin
        a5_table = '{
            '{0,   1'b1, 1'b1, 1}, '{1,   1'b0, 1'b1, 0}, '{16,  1'b0, 1'b1, 0},
            '{17,  1'b1, 1'b1, 0}, '{32,  1'b1, 1'b1, 0}, '{33,  1'b0, 1'b1, 0},
            '{49,  1'b1, 1'b1, 0}, '{65,  1'b0, 1'b1, 0}, '{81,  1'b0, 1'b1, 0},
            '{97,  1'b1, 1'b1, 0}, '{113, 1'b0, 1'b1, 0}, '{129, 1'b1, 1'b1, 0},
            '{144, 1'b1, 1'b1, 0}, '{145, 1'b1, 1'b1, 0}, '{160, 1'b1, 1'b1, 0},
            '{161, 1'b1, 1'b0, 0}
        };

        // Reset: three edges low, release, then a quiet line.
        @(posedge clock);
        #1;
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 8'h00);
        check("rst_tx", tx, 1'b1);
        check("rst_ready", byte_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_level", fifo_level, 0);
        idle(100);

        // Single byte 0xA5 against hand-derived waveform points.
        for (int off = 0; off <= 165; off++) begin
            tick(1'b1, off == 0, 8'hA5);
            for (int v = 0; v < 16; v++) begin
                if (a5_table[v].offset == off) begin
                    check("a5_tx", tx, a5_table[v].tx);
                    check("a5_busy", busy, a5_table[v].busy);
                    check("a5_level", fifo_level, a5_table[v].level);
                end
            end
        end
        idle(5);

        // Back-to-back 0x00 then 0xFF: stop bit then start bit with no gap.
        for (int off = 0; off <= 340; off++) begin
            tick(1'b1, off < 2, (off == 0) ? 8'h00 : 8'hFF);
            if (off == 144) check("b2b_last_data", tx, 1'b0);
            if (off == 145) check("b2b_stop_first", tx, 1'b1);
            if (off == 160) check("b2b_stop_last", tx, 1'b1);
            if (off == 161) check("b2b_second_start", tx, 1'b0);
            if (off == 177) check("b2b_second_bit0", tx, 1'b1);
        end
        idle(5);

        // FIFO full: ten consecutive offers, the tenth must be refused.
        for (int i = 1; i <= 10; i++) tick(1'b1, 1'b1, 8'(i));
        check("full_level", fifo_level, 8);
        check("full_ready", byte_ready, 1'b0);
        idle(9 * frame + 20);
        check("full_drained_busy", busy, 1'b0);

        // Reset during data bit 3 of 0x3C, then a clean 0xC3 frame.
        for (int off = 0; off <= 70; off++) tick(1'b1, off == 0, 8'h3C);
        tick(1'b0, 1'b0, 8'h00);
        check("midrst_tx", tx, 1'b1);
        check("midrst_level", fifo_level, 0);
        check("midrst_busy", busy, 1'b0);
        idle(3);
        tick(1'b1, 1'b1, 8'hC3);
        idle(frame + 10);

        // Pointer wrap: 20 bytes 0x10..0x23 offered at random, never while the model is full.
        begin
            int sent = 0;
            for (int c = 0; c < 5000 && sent < 20; c++) begin
                logic v;
                v = ($urandom_range(0, 1) == 1) && (model_q.size() != depth);
                tick(1'b1, v, 8'(8'h10 + sent));
                if (v) sent++;
            end
            check("wrap_all_sent", sent, 20);
        end
        idle(9 * frame + 20);

        // Random traffic, including offers against a full FIFO.
        for (int c = 0; c < 600; c++)
            tick(1'b1, $urandom_range(0, 2) == 0, 8'($urandom));
        idle(9 * frame + 20);
        check("final_idle_busy", busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mfp_uart_transmitter.md
Name: mfp_uart_transmitter

Overview:
- Byte-serial UART transmitter. The transmit-side counterpart of mfp_uart_receiver, using the same clock/baud parameterisation and 8N1 framing.
- Accepts bytes over a valid/ready handshake into an internal FIFO and serialises them on tx.
- Intended users: status and echo output from the UART loader path, and the later SREC dump path.

Parameters:
- clock_frequency, 50000000, system clock frequency in Hz.
- baud_rate, 115200, line bit rate.
- fifo_depth_log2, 3, log2 of FIFO depth (default depth 8 entries).

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- byte_data  input  8  byte to transmit.
- byte_valid  input  1  byte_data is offered this cycle.
- byte_ready  output  1  FIFO can accept a byte; a transfer occurs on an edge where byte_valid and byte_ready are both 1.
- tx  output  1  serial line, idle high.
- busy  output  1  a frame is in progress or the FIFO is non-empty.
- fifo_level  output  fifo_depth_log2+1  number of bytes stored in the FIFO, excluding the byte being shifted.

Behaviour:
- Reset (reset_n sampled low on an edge) forces:
  - tx=1, busy=0, fifo_level=0, byte_ready=1.
  - state IDLE, bit and baud counters cleared.
- Reset mid-frame aborts the frame: tx is 1 after that edge and FIFO contents are discarded.
- Bit timing:
  - cycles_per_bit = clock_frequency / baud_rate (integer truncation; 434 at defaults).
  - Every line bit is held for exactly cycles_per_bit clocks.
  - cycles_per_bit must be >= 2; parameter values below that are unsupported.
- Framing is 8N1: start bit 0, data bits LSB first, one stop bit 1.
- FIFO:
  - Circular buffer with wrapping read and write pointers, depth 2^fifo_depth_log2.
  - byte_ready = (fifo_level != depth), computed combinationally from the current level. There is no pass-through when full.
  - Push with byte_ready=0 is ignored: data dropped, level unchanged.
  - Simultaneous push and pop in the same cycle leaves fifo_level unchanged, and both operations take effect.
- State machine IDLE -> START -> DATA -> STOP:
  - IDLE:
    - tx=1.
    - If fifo_level != 0 on an edge: pop the head into the shift register, go to START, tx=0 from that edge.
  - START: hold tx=0 for cycles_per_bit clocks, then go to DATA with bit index 0.
  - DATA:
    - tx = shift[index].
    - After each bit period, index increments.
    - After index 7 completes, go to STOP.
  - STOP: hold tx=1 for cycles_per_bit clocks. On the last cycle of the stop period:
    - If FIFO non-empty: pop and go directly to START. No idle gap; the next start bit begins on the following edge.
    - Otherwise go to IDLE.
- Latency: a byte pushed into an empty FIFO with the transmitter IDLE on edge N is popped on edge N+1, and tx falls at edge N+1.
- Frame length is 10*cycles_per_bit clocks from the falling edge of the start bit to the end of the stop bit.
- busy = (state != IDLE) | (fifo_level != 0). It deasserts on the edge where STOP returns to IDLE.
- tx, busy and fifo_level are registered outputs (glitch-free tx).

Test Plan (clock_frequency=16, baud_rate=1, giving cycles_per_bit=16; fifo_depth_log2=3):
- Reset check: hold reset_n=0 for 3 edges, then release -> tx=1, byte_ready=1, busy=0, fifo_level=0, and tx stays 1 for 100 cycles with no input.
- Single byte: push 0xA5 on edge N ->
  - tx=0 over edges N+1..N+16;
  - then data bits 1,0,1,0,0,1,0,1, 16 cycles each;
  - then tx=1 stop bit;
  - busy falls at edge N+161.
- Back-to-back: push 0x00 then 0xFF on consecutive edges -> first frame's stop bit is immediately followed by the second start bit (exactly 16 high cycles between the last data bit of 0x00 and the start bit of 0xFF); decoded bytes are 0x00 then 0xFF.
- FIFO full: push 0x01..0x0A with byte_valid held high on 10 consecutive edges ->
  - 9 bytes accepted (first popped at once, 8 stored);
  - fifo_level reaches 8 and byte_ready=0 from then;
  - 0x0A dropped;
  - line carries exactly 0x01..0x09 in order.
- Reset mid-frame: push 0x3C, assert reset_n=0 for one edge during data bit 3 -> tx=1 on the next edge, fifo_level=0, busy=0. Then push 0xC3 -> a complete, correct 0xC3 frame follows.
- Pointer wrap: stream 20 bytes 0x10..0x23 while respecting byte_ready -> all 20 bytes decoded in order, with no loss or duplication across pointer wrap-around.
